// File: rtl/machdem_pkg.sv
// Shared state encoding and default widths for the counter run controller.
package machdem_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int PRESC_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/machdem_presc.sv
// Prescaler: tick is high while the count equals the limit; the count wraps to 0 on tick and freezes on hold.
// Zero latency on tick (combinational compare of a register); no backpressure.
module machdem_presc #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clr,
  input  logic               i_hold,
  input  logic [PRESC_W-1:0] i_limit,
  output logic               o_tick
);

  logic [PRESC_W-1:0] r_cnt;

  assign o_tick = (r_cnt == i_limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      r_cnt <= o_tick ? '0 : r_cnt + PRESC_W'(1);
    end
  end

  // Limit is latched before counting starts, so the count can never pass it.
  a_no_overrun: assert property (@(posedge clk) disable iff (!reset)
    !i_clr |-> r_cnt <= i_limit);

endmodule

// File: rtl/machdem_run_ctrl.sv
// Run controller: clear the counter, then enable it once every presc+1 clocks until q == target, then pulse done.
// start->CLEAR in 1 cycle, done target*(presc+1)+3 cycles after start; pause freezes the run, abort returns to IDLE.
module machdem_run_ctrl
  import machdem_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic [WIDTH-1:0]   target,
  input  logic [PRESC_W-1:0] presc,
  input  logic [WIDTH-1:0]   cnt_q,
  output logic               cnt_clr,
  output logic               cnt_en,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_o
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_target_l;
  logic [PRESC_W-1:0] r_presc_l;
  logic               w_match;
  logic               w_tick;

  assign w_match = (cnt_q == r_target_l);

  // Prescaler only advances in RUN, so it re-enters every run from zero.
  machdem_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (r_state != ST_RUN),
    .i_hold  (pause),
    .i_limit (r_presc_l),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_target_l <= '0;
      r_presc_l  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_target_l <= target;
            r_presc_l  <= presc;
            r_state    <= ST_CLEAR;
          end
        end
        ST_CLEAR: r_state <= abort ? ST_IDLE : ST_RUN;
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (w_match) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes to the counter are suppressed in the cycle abort is seen; done stays a pure state decode.
  assign cnt_clr = (r_state == ST_CLEAR) && !abort;
  assign cnt_en  = (r_state == ST_RUN) && !abort && !w_match && !pause && w_tick;
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign state_o = r_state;

  a_done_one_cycle: assert property (@(posedge clk) disable iff (!reset)
    r_state == ST_DONE |=> r_state == ST_IDLE);

endmodule
